// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues word fetches over a req/ack handshake, buffers up to two
// returned words and presents {instruction, pc+4} to the IF/ID register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_output,
  output logic [31:0] pc_plus_4
);

  typedef enum logic [1:0] {REQ, FULL, SQUASH} state_t;

  state_t      state_q;
  logic [31:0] req_addr_q;
  logic [31:0] tgt_q;
  logic [31:0] instr_q [2];
  logic [31:0] pc4_q   [2];
  logic [1:0]  count_q;

  logic        pop;
  logic        push;
  logic [1:0]  count_d;
  logic [31:0] tgt_aligned;
  logic [31:0] pc4_new;

  assign tgt_aligned = redirect_target & ~32'h3;
  assign pc4_new     = req_addr_q + 32'd4;
  assign pop         = ~stall & (count_q != 2'd0) & ~redirect;
  assign push        = (state_q == REQ) & imem_ack & ~redirect;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  assign imem_req           = (state_q != FULL) & ~reset;
  assign imem_addr          = req_addr_q;
  assign instruction_output = (count_q != 2'd0) ? instr_q[0] : NOP_INSTR;
  assign pc_plus_4          = (count_q != 2'd0) ? pc4_q[0]   : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= REQ;
      req_addr_q <= RESET_PC;
      tgt_q      <= 32'd0;
      count_q    <= 2'd0;
      instr_q[0] <= NOP_INSTR;
      instr_q[1] <= NOP_INSTR;
      pc4_q[0]   <= 32'd0;
      pc4_q[1]   <= 32'd0;
    end else if (redirect) begin
      count_q <= 2'd0;
      // While a request is on the bus its address must not move until acked.
      case (state_q)
        FULL: begin
          req_addr_q <= tgt_aligned;
          state_q    <= REQ;
        end
        default: begin
          if (imem_ack) begin
            req_addr_q <= tgt_aligned;
            state_q    <= REQ;
          end else begin
            tgt_q   <= tgt_aligned;
            state_q <= SQUASH;
          end
        end
      endcase
    end else begin
      count_q <= count_d;
      if (pop) begin
        instr_q[0] <= instr_q[1];
        pc4_q[0]   <= pc4_q[1];
      end
      // The new word lands in the slot just past the post-pop head.
      if (push) begin
        req_addr_q <= pc4_new;
        if (count_d == 2'd1) begin
          instr_q[0] <= imem_rdata;
          pc4_q[0]   <= pc4_new;
        end else begin
          instr_q[1] <= imem_rdata;
          pc4_q[1]   <= pc4_new;
        end
      end
      case (state_q)
        REQ: begin
          if (count_d == 2'd2) state_q <= FULL;
        end
        FULL: begin
          if (pop) state_q <= REQ;
        end
        SQUASH: begin
          if (imem_ack) begin
            req_addr_q <= tgt_q;
            state_q    <= REQ;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a cycle table of inputs and
// expected outputs, plus a hand-written asynchronous reset sequence.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_output;
  logic [31:0] pc_plus_4;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch_unit dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .redirect           (redirect),
    .redirect_target    (redirect_target),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ack           (imem_ack),
    .imem_rdata         (imem_rdata),
    .instruction_output (instruction_output),
    .pc_plus_4          (pc_plus_4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] instr, input logic [31:0] pc4);
    chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".addr"},  imem_addr, addr);
    chk({tag, ".instr"}, instruction_output, instr);
    chk({tag, ".pc4"},   pc_plus_4, pc4);
  endtask

  initial begin
    //               stall redir tgt            ack rdata          req addr           instr          pc4
    // steady stream, acks every cycle
    vecs.push_back('{0, 0, 32'h0,          1, 32'hC000_0000, 1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{0, 0, 32'h0,          1, 32'hC000_0004, 1, 32'h0000_0004, 32'hC000_0000, 32'h0000_0004});
    vecs.push_back('{0, 0, 32'h0,          1, 32'hC000_0008, 1, 32'h0000_0008, 32'hC000_0004, 32'h0000_0008});
    // stall 5 cycles: queue fills, request dropped
    vecs.push_back('{1, 0, 32'h0,          1, 32'hC000_000C, 1, 32'h0000_000C, 32'hC000_0008, 32'h0000_000C});
    vecs.push_back('{1, 0, 32'h0,          0, 32'h0,         0, 32'h0000_0010, 32'hC000_0008, 32'h0000_000C});
    vecs.push_back('{1, 0, 32'h0,          0, 32'h0,         0, 32'h0000_0010, 32'hC000_0008, 32'h0000_000C});
    vecs.push_back('{1, 0, 32'h0,          0, 32'h0,         0, 32'h0000_0010, 32'hC000_0008, 32'h0000_000C});
    vecs.push_back('{1, 0, 32'h0,          0, 32'h0,         0, 32'h0000_0010, 32'hC000_0008, 32'h0000_000C});
    vecs.push_back('{0, 0, 32'h0,          0, 32'h0,         0, 32'h0000_0010, 32'hC000_0008, 32'h0000_000C});
    vecs.push_back('{0, 0, 32'h0,          1, 32'hC000_0010, 1, 32'h0000_0010, 32'hC000_000C, 32'h0000_0010});
    vecs.push_back('{0, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0014, 32'hC000_0010, 32'h0000_0014});
    // redirect on first wait cycle -> SQUASH, old request held, response discarded
    vecs.push_back('{0, 1, 32'h0000_0100,  0, 32'h0,         1, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{0, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{0, 0, 32'h0,          1, 32'hC000_0014, 1, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{0, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{0, 0, 32'h0,          1, 32'hC000_0100, 1, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{1, 0, 32'h0,          1, 32'hC000_0104, 1, 32'h0000_0104, 32'hC000_0100, 32'h0000_0104});
    // redirect while FULL and stalled, unaligned target
    vecs.push_back('{1, 1, 32'h0000_0203,  0, 32'h0,         0, 32'h0000_0108, 32'hC000_0100, 32'h0000_0104});
    // two redirects in a row while waiting: latest target wins
    vecs.push_back('{0, 1, 32'h0000_0300,  0, 32'h0,         1, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{0, 1, 32'hFFFF_FFFE,  0, 32'h0,         1, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{0, 0, 32'h0,          1, 32'hC000_0200, 1, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000});
    // fetch at the top of the address space wraps
    vecs.push_back('{0, 0, 32'h0,          1, 32'h3C00_0FFC, 1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{0, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0000, 32'h3C00_0FFC, 32'h0000_0000});
    // redirect coinciding with an ack in REQ: response dropped
    vecs.push_back('{0, 1, 32'h0000_0040,  1, 32'hDEAD_BEEF, 1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{1, 0, 32'h0,          1, 32'hC000_0040, 1, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{1, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0044, 32'hC000_0040, 32'h0000_0044});

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #1;
    chk_all("rst", 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      stall           = vecs[i].stall;
      redirect        = vecs[i].redir;
      redirect_target = vecs[i].tgt;
      imem_ack        = vecs[i].ack;
      imem_rdata      = vecs[i].rdata;
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].instr, vecs[i].pc4);
    end

    // async reset mid-wait with a word queued, then restart from RESET_PC
    reset = 1'b1;
    #1;
    chk_all("arst", 1'b0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0; stall = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk_all("rs0", 1'b1, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(negedge clk);
    chk_all("rs1", 1'b1, 32'h4, 32'h1234_5678, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
